// File: rtl/psum_drain_serializer.sv
// Snapshot a row of PE accumulators and serialize them over valid/ready.
// Optional saturation of oversized psums is enabled with macro PSUM_SAT_EN.
module psum_drain_serializer #(
   parameter int DW   = 16,
   parameter int N_PE = 8,
   parameter int OW   = 16,
   parameter int IDXW = $clog2(N_PE)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   capture,
   input  logic [N_PE*2*DW-1:0]   psum_in,
   output logic                   busy,
   output logic                   cap_drop,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OW-1:0]          out_data,
   output logic [IDXW-1:0]        out_idx,
   output logic                   out_last,
   output logic                   out_sat
);

   localparam int PW = 2 * DW;
   localparam logic [IDXW-1:0] LAST = IDXW'(N_PE - 1);

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [IDXW-1:0] idx_q;
   logic [IDXW-1:0] idx_d;
   logic            cap_drop_q;
   logic            cap_drop_d;
   logic            load_d;
   logic [PW-1:0]   shadow_q [N_PE];

   logic            draining;
   logic            hs;
   logic            last_beat;
   logic [PW-1:0]   cur;
   logic [PW-1:0]   hi;
   logic            over;

   assign draining  = (state_q == DRAIN);
   assign hs        = draining & out_ready;
   assign last_beat = (idx_q == LAST);

   // Next-state decisions: beat advance, snapshot load, rejected capture.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      load_d     = 1'b0;
      cap_drop_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (capture) begin
               load_d  = 1'b1;
               idx_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (hs && !last_beat) begin
               idx_d      = idx_q + 1'b1;
               cap_drop_d = capture;
            end else if (hs) begin
               idx_d = '0;
               if (capture) begin
                  load_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cap_drop_d = capture;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, index, drop pulse and shadow snapshot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cap_drop_q <= 1'b0;
         for (int i = 0; i < N_PE; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cap_drop_q <= cap_drop_d;
         if (load_d) begin
            for (int i = 0; i < N_PE; i++) begin
               shadow_q[i] <= psum_in[i*PW +: PW];
            end
         end
      end
   end

   // Output word: pure mux of registered shadow by registered index.
   assign cur = shadow_q[idx_q];
   assign hi  = cur >> OW;

`ifdef PSUM_SAT_EN
   assign over     = |hi;
   assign out_data = over ? {OW{1'b1}} : cur[OW-1:0];
   assign out_sat  = draining & over;
`else
   logic unused_hi;
   assign unused_hi = ^hi;
   assign over      = 1'b0;
   assign out_data  = cur[OW-1:0];
   assign out_sat   = over;
`endif

   assign out_valid = draining;
   assign busy      = draining;
   assign out_idx   = idx_q;
   assign out_last  = draining & last_beat;
   assign cap_drop  = cap_drop_q;

endmodule

// File: tb/tb_psum_drain_serializer.sv
// Randomized and directed bench for psum_drain_serializer.
// Reference model is a queue of pending beats built from each accepted snapshot.
module tb_psum_drain_serializer;

   localparam int DW   = 16;
   localparam int N_PE = 4;
   localparam int OW   = 16;
   localparam int IDXW = 2;

   logic                 clk;
   logic                 rst_n;
   logic                 capture;
   logic [N_PE*2*DW-1:0] psum_in;
   logic                 busy;
   logic                 cap_drop;
   logic                 out_valid;
   logic                 out_ready;
   logic [OW-1:0]        out_data;
   logic [IDXW-1:0]      out_idx;
   logic                 out_last;
   logic                 out_sat;

   int checks;
   int errors;

   psum_drain_serializer #(
      .DW(DW), .N_PE(N_PE), .OW(OW), .IDXW(IDXW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .capture(capture),
      .psum_in(psum_in),
      .busy(busy),
      .cap_drop(cap_drop),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_idx(out_idx),
      .out_last(out_last),
      .out_sat(out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] exp_data(input logic [31:0] p);
`ifdef PSUM_SAT_EN
      if (p > 32'h0000_FFFF) return 16'hFFFF;
`endif
      return p[15:0];
   endfunction

   function automatic logic exp_sat(input logic [31:0] p);
`ifdef PSUM_SAT_EN
      return p > 32'h0000_FFFF;
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ps(input logic [31:0] a, b, c, d);
      psum_in = {d, c, b, a};
   endtask

   task automatic chk_beat(input string nm, input int k, input logic [31:0] p);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_valid k=%0d got v=%b b=%b exp 1", nm, k, out_valid, busy);
      end
      checks++;
      if (out_idx !== k[IDXW-1:0]) begin
         errors++;
         $display("FAIL %s_idx got %0d exp %0d", nm, out_idx, k);
      end
      checks++;
      if (out_data !== exp_data(p)) begin
         errors++;
         $display("FAIL %s_data k=%0d got %h exp %h", nm, k, out_data, exp_data(p));
      end
      checks++;
      if (out_last !== (k == N_PE - 1)) begin
         errors++;
         $display("FAIL %s_last k=%0d got %b", nm, k, out_last);
      end
      checks++;
      if (out_sat !== exp_sat(p)) begin
         errors++;
         $display("FAIL %s_sat k=%0d got %b exp %b", nm, k, out_sat, exp_sat(p));
      end
   endtask

   task automatic chk_idle(input string nm);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle got v=%b b=%b exp 0", nm, out_valid, busy);
      end
   endtask

   task automatic chk_drop(input string nm, input logic e);
      checks++;
      if (cap_drop !== e) begin
         errors++;
         $display("FAIL %s_cap_drop got %b exp %b", nm, cap_drop, e);
      end
   endtask

   task automatic start_basic();
      set_ps(32'd5, 32'd10, 32'h0001_0000, 32'd7);
      capture   = 1'b1;
      out_ready = 1'b1;
      tick();
      capture = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      capture   = 1'b0;
      out_ready = 1'b0;
      psum_in   = '0;
      #3;
      checks++;
      if ({busy, cap_drop, out_valid, out_last, out_sat, out_idx, out_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got b=%b d=%b v=%b l=%b s=%b i=%0d data=%h exp all 0",
                  busy, cap_drop, out_valid, out_last, out_sat, out_idx, out_data);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk_idle("reset");
   endtask

   task automatic test_basic();
      logic [31:0] p [4];
      p = '{32'd5, 32'd10, 32'h0001_0000, 32'd7};
      start_basic();
      for (int k = 0; k < N_PE; k++) begin
         chk_beat("basic", k, p[k]);
         tick();
      end
      chk_idle("basic_end");
   endtask

   task automatic test_stall();
      start_basic();
      chk_beat("stall0", 0, 32'd5);
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk_beat("stall_hold", 1, 32'd10);
         tick();
      end
      out_ready = 1'b1;
      chk_beat("stall_rel", 1, 32'd10);
      tick();
      chk_beat("stall2", 2, 32'h0001_0000);
      tick();
      chk_beat("stall3", 3, 32'd7);
      tick();
      chk_idle("stall_end");
   endtask

   task automatic test_cap_drop();
      start_basic();
      tick();
      chk_beat("drop1", 1, 32'd10);
      chk_drop("drop_pre", 1'b0);
      set_ps(32'd100, 32'd200, 32'd300, 32'd400);
      capture = 1'b1;
      tick();
      capture = 1'b0;
      chk_drop("drop_pulse", 1'b1);
      chk_beat("drop2", 2, 32'h0001_0000);
      tick();
      chk_drop("drop_after", 1'b0);
      chk_beat("drop3", 3, 32'd7);
      tick();
      chk_idle("drop_end");
   endtask

   task automatic test_back_to_back();
      start_basic();
      tick();
      tick();
      tick();
      chk_beat("b2b_last", 3, 32'd7);
      set_ps(32'd1, 32'd2, 32'd3, 32'd4);
      capture = 1'b1;
      tick();
      capture = 1'b0;
      chk_drop("b2b", 1'b0);
      for (int k = 0; k < N_PE; k++) begin
         chk_beat("b2b_new", k, 32'(k + 1));
         tick();
      end
      chk_idle("b2b_end");
   endtask

   task automatic test_reset_mid();
      start_basic();
      tick();
      tick();
      chk_beat("rmid2", 2, 32'h0001_0000);
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== '0) begin
         errors++;
         $display("FAIL rmid_async got v=%b b=%b i=%0d exp 0", out_valid, busy, out_idx);
      end
      #1;
      rst_n = 1'b1;
      tick();
      chk_idle("rmid_idle");
      set_ps(32'd9, 32'd8, 32'h0002_0001, 32'd6);
      capture = 1'b1;
      tick();
      capture = 1'b0;
      chk_beat("rmid_new0", 0, 32'd9);
      tick();
      chk_beat("rmid_new1", 1, 32'd8);
      tick();
      chk_beat("rmid_new2", 2, 32'h0002_0001);
      tick();
      chk_beat("rmid_new3", 3, 32'd6);
      tick();
      chk_idle("rmid_end");
   endtask

   task automatic test_random();
      logic [31:0] q_ps [$];
      int          q_ix [$];
      logic        exp_drop;
      logic        cap;
      logic        rdy;
      logic        acc;
      logic [31:0] np [4];
      exp_drop = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         chk_drop("rnd", exp_drop);
         if (q_ps.size() == 0) begin
            chk_idle("rnd");
         end else begin
            chk_beat("rnd", q_ix[0], q_ps[0]);
         end
         cap = ($urandom_range(0, 5) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         if (cyc >= 580) cap = 1'b0;
         for (int i = 0; i < 4; i++) begin
            np[i] = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 65535));
         end
         capture   = cap;
         out_ready = rdy;
         set_ps(np[0], np[1], np[2], np[3]);
         acc = cap && (q_ps.size() == 0 || (q_ps.size() == 1 && rdy));
         exp_drop = cap && !acc;
         if (q_ps.size() > 0 && rdy) begin
            void'(q_ps.pop_front());
            void'(q_ix.pop_front());
         end
         if (acc) begin
            for (int i = 0; i < 4; i++) begin
               q_ps.push_back(np[i]);
               q_ix.push_back(i);
            end
         end
         tick();
      end
      capture   = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && q_ps.size() > 0; c++) begin
         void'(q_ps.pop_front());
         void'(q_ix.pop_front());
         tick();
      end
      checks++;
      if (q_ps.size() != 0) begin
         errors++;
         $display("FAIL rnd_drain_bound got %0d pending exp 0", q_ps.size());
      end
      chk_idle("rnd_end");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_stall();
      test_cap_drop();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
